fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation RV32I core. It replaces the combinational PC→i_mem path with a request/response IMEM interface of arbitrary latency, a credit-limited prefetch queue of DEPTH entries and a valid/ready instruction output to decode. It takes a redirect (branch/jump target) from execute, flushes wrong-path instructions and discards in-flight responses.

---
 rtl/core_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-path types and constants for the RV32I core front end.
package core_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch queue of {pc, insn}; flush empties it in one cycle.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_push_data,
  input  logic          i_pop,
  output fetch_entry_t  o_head,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_push_ok = i_push && !i_flush && (int'(r_count) < DEPTH);
  assign w_pop_ok  = i_pop && !i_flush && (r_count != '0);

  // Payload storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited IMEM requests, prefetch queue,
// redirect flush with discard of in-flight responses.
module fetch_unit
  import core_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic        o_imem_req_vld,
  input  logic        i_imem_req_rdy,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_vld,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_insn_vld,
  input  logic        i_insn_rdy,
  output logic [31:0] o_insn,
  output logic [31:0] o_insn_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_misalign,
  output logic [31:0] o_pc_debug
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_outst_dec;
  logic [31:0]   w_redirect_pc;
  logic          w_req_fire;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;

  // Queued plus in-flight words never exceed DEPTH, so every response has a slot.
  assign w_inflight     = {1'b0, w_count} + {1'b0, r_outstanding};
  assign o_imem_req_vld = i_reset && !i_redirect && (int'(w_inflight) < DEPTH);
  assign o_imem_addr    = r_fetch_pc;

  assign w_req_fire    = o_imem_req_vld && i_imem_req_rdy;
  assign w_drop        = i_imem_rsp_vld && (i_redirect || (r_discard != '0));
  assign w_push        = i_imem_rsp_vld && !w_drop;
  assign w_pop         = o_insn_vld && i_insn_rdy;
  assign w_outst_dec   = r_outstanding - CW'(i_imem_rsp_vld);
  assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
  assign w_push_entry  = '{pc: r_rsp_pc, insn: i_imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_reset),
    .i_flush     (i_redirect),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign o_insn_vld = (w_count != '0) && !i_redirect;
  assign o_insn     = w_head.insn;
  assign o_insn_pc  = w_head.pc;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      o_misalign    <= 1'b0;
      o_pc_debug    <= '0;
    end else begin
      r_outstanding <= w_outst_dec + CW'(w_req_fire);
      o_misalign    <= i_redirect && (i_redirect_pc[1:0] != 2'b00);
      if (w_pop) o_pc_debug <= o_insn_pc;
      if (i_redirect) begin
        // Everything still in flight after this cycle belongs to the wrong path.
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_discard  <= w_outst_dec;
      end else begin
        if (w_req_fire) r_fetch_pc <= pc_plus4(r_fetch_pc);
        if (w_push)     r_rsp_pc   <= pc_plus4(r_rsp_pc);
        if (w_drop)     r_discard  <= r_discard - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an IMEM model with variable latency,
// expected-PC queue filled by directed tests, monitor checks every delivered word.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        o_imem_req_vld;
  logic        i_imem_req_rdy = 1'b1;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_vld = 1'b0;
  logic [31:0] i_imem_rsp_data = '0;
  logic        o_insn_vld;
  logic        i_insn_rdy = 1'b0;
  logic [31:0] o_insn;
  logic [31:0] o_insn_pc;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_misalign;
  logic [31:0] o_pc_debug;

  int          n_checks = 0;
  int          n_fail = 0;
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_dbg = '0;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .o_imem_req_vld(o_imem_req_vld), .i_imem_req_rdy(i_imem_req_rdy), .o_imem_addr(o_imem_addr),
    .i_imem_rsp_vld(i_imem_rsp_vld), .i_imem_rsp_data(i_imem_rsp_data),
    .o_insn_vld(o_insn_vld), .i_insn_rdy(i_insn_rdy), .o_insn(o_insn), .o_insn_pc(o_insn_pc),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_misalign(o_misalign), .o_pc_debug(o_pc_debug)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses reset; returns at cycle 0 (first cycle with reset released).
  task automatic do_reset(input logic rdy);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    i_insn_rdy = 1'b0;
    i_redirect = 1'b0;
    step(2);
    acc_q.delete();
    i_insn_rdy = rdy;
    i_reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    i_redirect = 1'b1;
    i_redirect_pc = pc;
    @(negedge clk);
    chk("redir_no_req", {31'b0, o_imem_req_vld}, 32'd0);
    chk("redir_no_insn", {31'b0, o_insn_vld}, 32'd0);
    @(posedge clk);
    #1;
    i_redirect = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    i_insn_rdy = 1'b0;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // IMEM model: in-order responses lat cycles after acceptance, cleared by reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      i_imem_rsp_vld = 1'b0;
      if (!i_reset) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        i_imem_rsp_vld  = 1'b1;
        i_imem_rsp_data = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      @(negedge clk);
      if (i_reset && o_imem_req_vld && i_imem_req_rdy) begin
        pend_addr.push_back(o_imem_addr);
        pend_due.push_back(cyc + lat);
        acc_q.push_back(o_imem_addr);
      end
    end
  end

  // Monitor: pops the expected queue on every accepted instruction.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!i_reset) begin
        exp_dbg = '0;
      end else begin
        chk("pc_debug", o_pc_debug, exp_dbg);
        if (o_insn_vld && i_insn_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_insn_pc", o_insn_pc, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("insn_pc", o_insn_pc, e);
            chk("insn_data", o_insn, mem_word(e));
            exp_dbg = e;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_req_vld", {31'b0, o_imem_req_vld}, 32'd0);
    chk("rst_insn_vld", {31'b0, o_insn_vld}, 32'd0);
    chk("rst_insn", o_insn, 32'd0);
    chk("rst_insn_pc", o_insn_pc, 32'd0);
    chk("rst_misalign", {31'b0, o_misalign}, 32'd0);
    chk("rst_pc_debug", o_pc_debug, 32'd0);

    // 1: latency 1, decode always ready, one instruction per cycle
    lat = 1;
    push_seq(32'h0, 16);
    do_reset(1'b1);
    @(negedge clk);
    chk("t1_req_vld_c0", {31'b0, o_imem_req_vld}, 32'd1);
    chk("t1_addr_c0", o_imem_addr, 32'h0);
    @(negedge clk);
    chk("t1_insn_vld_c1", {31'b0, o_insn_vld}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t1_stream_vld", {31'b0, o_insn_vld}, 32'd1);
      if (i == 0) chk("t1_first_pc_c2", o_insn_pc, 32'h0);
    end
    @(posedge clk);
    #1;
    i_insn_rdy = 1'b0;
    chk("t1_drained", 32'(exp_q.size()), 32'd0);
    chk("t1_req1", acc_q[1], 32'h4);
    chk("t1_req2", acc_q[2], 32'h8);

    // 2: decode stalled, queue fills, one pop frees one credit
    do_reset(1'b0);
    step(10);
    chk("t2_req_count", 32'(acc_q.size()), 32'd4);
    chk("t2_last_req", acc_q[3], 32'hC);
    @(negedge clk);
    chk("t2_full_no_req", {31'b0, o_imem_req_vld}, 32'd0);
    chk("t2_full_vld", {31'b0, o_insn_vld}, 32'd1);
    exp_q.push_back(32'h0);
    @(posedge clk);
    #1;
    i_insn_rdy = 1'b1;
    step(1);
    i_insn_rdy = 1'b0;
    step(6);
    chk("t2_req_count2", 32'(acc_q.size()), 32'd5);
    chk("t2_extra_req", acc_q[4], 32'h10);
    chk("t2_popped", 32'(exp_q.size()), 32'd0);

    // 3: latency 3, redirect with responses in flight
    lat = 3;
    do_reset(1'b0);
    step(5);
    redirect(32'h100);
    @(negedge clk);
    chk("t3_flushed", {31'b0, o_insn_vld}, 32'd0);
    push_seq(32'h100, 8);
    @(posedge clk);
    #1;
    i_insn_rdy = 1'b1;
    wait_drain("t3_drain", 80);
    chk("t3_redir_req", acc_q[4], 32'h100);

    // 4: misaligned redirect target
    lat = 1;
    do_reset(1'b0);
    step(3);
    redirect(32'h102);
    @(negedge clk);
    chk("t4_misalign_pulse", {31'b0, o_misalign}, 32'd1);
    chk("t4_req_vld", {31'b0, o_imem_req_vld}, 32'd1);
    chk("t4_req_addr", o_imem_addr, 32'h100);
    @(negedge clk);
    chk("t4_misalign_end", {31'b0, o_misalign}, 32'd0);
    push_seq(32'h100, 4);
    @(posedge clk);
    #1;
    i_insn_rdy = 1'b1;
    wait_drain("t4_drain", 40);

    // 5: redirect + incoming response + decode ready in one cycle
    push_seq(32'h0, 3);
    push_seq(32'h200, 4);
    do_reset(1'b1);
    step(5);
    redirect(32'h200);
    @(negedge clk);
    chk("t5_empty", {31'b0, o_insn_vld}, 32'd0);
    chk("t5_pc_debug", o_pc_debug, 32'h8);
    wait_drain("t5_drain", 40);

    // 6: asynchronous reset with a full queue
    do_reset(1'b0);
    step(8);
    push_seq(32'h0, 2);
    i_insn_rdy = 1'b1;
    step(2);
    i_insn_rdy = 1'b0;
    step(6);
    @(negedge clk);
    chk("t6_full_vld", {31'b0, o_insn_vld}, 32'd1);
    chk("t6_head_pc", o_insn_pc, 32'h8);
    chk("t6_pc_debug", o_pc_debug, 32'h4);
    @(posedge clk);
    #3;
    i_reset = 1'b0;
    #1;
    chk("t6_async_insn_vld", {31'b0, o_insn_vld}, 32'd0);
    chk("t6_async_insn", o_insn, 32'd0);
    chk("t6_async_insn_pc", o_insn_pc, 32'd0);
    chk("t6_async_req_vld", {31'b0, o_imem_req_vld}, 32'd0);
    chk("t6_async_pc_debug", o_pc_debug, 32'd0);
    push_seq(32'h0, 3);
    step(2);
    acc_q.delete();
    i_insn_rdy = 1'b1;
    i_reset = 1'b1;
    @(negedge clk);
    chk("t6_restart_addr", o_imem_addr, 32'h0);
    wait_drain("t6_drain", 40);
    chk("t6_first_req", acc_q[0], 32'h0);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
